// File: rtl/hc4e_pkg.sv
// hc4e_pkg: shared opcodes, run-state encoding and default widths for the HC4e run controller.
package hc4e_pkg;
  localparam int HC4E_PC_W = 8;
  localparam logic [2:0] CMD_SET_ADDR = 3'd0;
  localparam logic [2:0] CMD_LOAD = 3'd1;
  localparam logic [2:0] CMD_RUN = 3'd2;
  localparam logic [2:0] CMD_HALT = 3'd3;
  localparam logic [2:0] CMD_STEP = 3'd4;
  localparam logic [2:0] CMD_SET_BP = 3'd5;
  localparam logic [2:0] CMD_CLR_BP = 3'd6;
  localparam logic [2:0] CMD_SOFT_RESET = 3'd7;
  typedef enum logic [1:0] {ST_RST, ST_HALT, ST_RUN, ST_STEP} state_t;
endpackage

// File: rtl/hc4e_run_ctrl_if.sv
// hc4e_run_ctrl_if: host command port, core control and ROM write signals of the run controller.
interface hc4e_run_ctrl_if #(
  parameter int PC_W = 8,
  parameter int BP_IDX_W = 1
);
  logic cmd_valid;
  logic cmd_ready;
  logic [2:0] cmd_op;
  logic [PC_W-1:0] cmd_arg;
  logic [BP_IDX_W-1:0] cmd_idx;
  logic [PC_W-1:0] pc_in;
  logic cpu_en;
  logic cpu_rst_n;
  logic rom_we;
  logic [PC_W-1:0] rom_addr;
  logic [7:0] rom_wdata;
  logic halted;
  logic bp_hit;
  logic [BP_IDX_W-1:0] bp_id;
  modport master (
    output cmd_valid, cmd_op, cmd_arg, cmd_idx, pc_in,
    input cmd_ready, cpu_en, cpu_rst_n, rom_we, rom_addr, rom_wdata, halted, bp_hit, bp_id
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_arg, cmd_idx, pc_in,
    output cmd_ready, cpu_en, cpu_rst_n, rom_we, rom_addr, rom_wdata, halted, bp_hit, bp_id
  );
endinterface

// File: rtl/hc4e_bp_match.sv
// hc4e_bp_match: PC breakpoint registers with a lowest-index-wins match encoder.
module hc4e_bp_match
  import hc4e_pkg::*;
#(
  parameter int PC_W = HC4E_PC_W,
  parameter int NUM_BP = 2,
  parameter int BP_IDX_W = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                set_i,
  input  logic                clr_i,
  input  logic [BP_IDX_W-1:0] idx_i,
  input  logic [PC_W-1:0]     addr_i,
  input  logic [PC_W-1:0]     pc_i,
  output logic                match_o,
  output logic [BP_IDX_W-1:0] idx_o
);
  logic [PC_W-1:0] addr_q [NUM_BP];
  logic [NUM_BP-1:0] en_q;
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      en_q <= '0;
      for (int i = 0; i < NUM_BP; i++) addr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_BP; i++)
        if (idx_i == BP_IDX_W'(i)) begin
          if (set_i) begin
            addr_q[i] <= addr_i;
            en_q[i] <= 1'b1;
          end
          if (clr_i) en_q[i] <= 1'b0;
        end
    end
  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_BP - 1; i >= 0; i--)
      if (en_q[i] && addr_q[i] == pc_i) begin
        match_o = 1'b1;
        idx_o = BP_IDX_W'(i);
      end
  end
endmodule

// File: rtl/hc4e_run_ctrl.sv
// hc4e_run_ctrl: gates HC4e execution (run/halt/step/soft reset), matches breakpoints, loads ROM while halted.
module hc4e_run_ctrl
  import hc4e_pkg::*;
#(
  parameter int PC_W = HC4E_PC_W,
  parameter int NUM_BP = 2,
  parameter int BP_IDX_W = 1,
  parameter int RST_CYC = 2
) (
  input logic clk,
  input logic nReset,
  hc4e_run_ctrl_if.slave bus
);
  localparam int CW = $clog2(RST_CYC + 1);
  state_t state_q;
  logic [CW-1:0] rcnt_q;
  logic [PC_W-1:0] step_cnt_q, load_ptr_q, rom_addr_q;
  logic [7:0] rom_wdata_q;
  logic skip_bp_q, rom_we_q, bp_hit_q, cpu_rst_n_q;
  logic [BP_IDX_W-1:0] bp_id_q, match_idx;
  logic [2:0] op;
  logic bp_match, xfer, bp_stop, in_halt, busy;
  assign op = bus.cmd_op;
  assign in_halt = state_q == ST_HALT;
  assign busy = state_q == ST_RUN || state_q == ST_STEP;
  assign bus.cmd_ready = in_halt || (busy && (op == CMD_HALT || op == CMD_SOFT_RESET));
  assign xfer = bus.cmd_valid && bus.cmd_ready;
  assign bp_stop = state_q == ST_RUN && bp_match && !skip_bp_q;
  assign bus.cpu_en = state_q == ST_STEP || (state_q == ST_RUN && !bp_stop);
  assign bus.cpu_rst_n = cpu_rst_n_q;
  assign bus.halted = in_halt;
  assign bus.rom_we = rom_we_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rom_wdata = rom_wdata_q;
  assign bus.bp_hit = bp_hit_q;
  assign bus.bp_id = bp_id_q;
  hc4e_bp_match #(
    .PC_W(PC_W),
    .NUM_BP(NUM_BP),
    .BP_IDX_W(BP_IDX_W)
  ) u_bp (
    .clk(clk),
    .nReset(nReset),
    .set_i(xfer && in_halt && op == CMD_SET_BP),
    .clr_i(xfer && in_halt && op == CMD_CLR_BP),
    .idx_i(bus.cmd_idx),
    .addr_i(bus.cmd_arg),
    .pc_i(bus.pc_in),
    .match_o(bp_match),
    .idx_o(match_idx)
  );
  always_ff @(posedge clk or negedge nReset)
    if (!nReset) begin
      state_q <= ST_RST;
      rcnt_q <= CW'(RST_CYC);
      cpu_rst_n_q <= 1'b0;
      step_cnt_q <= '0;
      skip_bp_q <= 1'b0;
      load_ptr_q <= '0;
      rom_we_q <= 1'b0;
      rom_addr_q <= '0;
      rom_wdata_q <= '0;
      bp_hit_q <= 1'b0;
      bp_id_q <= '0;
    end else begin
      rom_we_q <= 1'b0;
      bp_hit_q <= 1'b0;
      case (state_q)
        ST_RST: begin
          rcnt_q <= rcnt_q - CW'(1);
          if (rcnt_q == CW'(1)) begin
            state_q <= ST_HALT;
            cpu_rst_n_q <= 1'b1;
          end
        end
        ST_HALT: if (xfer) begin
          if (op == CMD_SET_ADDR) load_ptr_q <= bus.cmd_arg;
          if (op == CMD_LOAD) begin
            rom_we_q <= 1'b1;
            rom_addr_q <= load_ptr_q;
            rom_wdata_q <= bus.cmd_arg[7:0];
            load_ptr_q <= load_ptr_q + PC_W'(1);
          end
          if (op == CMD_RUN) begin
            state_q <= ST_RUN;
            skip_bp_q <= 1'b1;
          end
          if (op == CMD_STEP && bus.cmd_arg != '0) begin
            state_q <= ST_STEP;
            step_cnt_q <= bus.cmd_arg;
          end
        end
        ST_RUN: begin
          skip_bp_q <= 1'b0;
          if (bp_stop) begin
            state_q <= ST_HALT;
            bp_hit_q <= 1'b1;
            bp_id_q <= match_idx;
          end else if (xfer && op == CMD_HALT) state_q <= ST_HALT;
        end
        ST_STEP: begin
          step_cnt_q <= step_cnt_q - PC_W'(1);
          if (step_cnt_q == PC_W'(1) || (xfer && op == CMD_HALT)) state_q <= ST_HALT;
        end
      endcase
      // Soft reset overrides everything above, including a coincident breakpoint stop.
      if (xfer && op == CMD_SOFT_RESET) begin
        state_q <= ST_RST;
        rcnt_q <= CW'(RST_CYC);
        cpu_rst_n_q <= 1'b0;
        load_ptr_q <= '0;
        skip_bp_q <= 1'b0;
        bp_hit_q <= 1'b0;
      end
    end
endmodule

// File: tb/tb_hc4e_run_ctrl.sv
// tb_hc4e_run_ctrl: directed + randomized checks of hc4e_run_ctrl against a PC/ROM/breakpoint reference model.
module tb_hc4e_run_ctrl;
  import hc4e_pkg::*;
  localparam int PC_W = 8;
  localparam int NUM_BP = 2;
  localparam int BP_IDX_W = 1;
  localparam int RST_CYC = 2;
  logic clk = 1'b0;
  logic nReset = 1'b0;
  always #5 clk = ~clk;
  hc4e_run_ctrl_if #(.PC_W(PC_W), .BP_IDX_W(BP_IDX_W)) bus ();
  hc4e_run_ctrl #(
    .PC_W(PC_W),
    .NUM_BP(NUM_BP),
    .BP_IDX_W(BP_IDX_W),
    .RST_CYC(RST_CYC)
  ) dut (
    .clk(clk),
    .nReset(nReset),
    .bus(bus)
  );
  int checks = 0;
  int fails = 0;
  int en_cnt = 0;
  int hit_cnt = 0;
  logic [BP_IDX_W-1:0] last_id = '0;
  logic [7:0] pc = 8'h00;
  logic [7:0] ptr = 8'h00;
  logic [7:0] bp_addr [NUM_BP];
  logic bp_en [NUM_BP];
  logic [15:0] exp_q [$];
  assign bus.pc_in = pc;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: observe pre-edge outputs, then advance the CPU model's PC.
  task automatic tick();
    logic en, rst_lo;
    logic [15:0] e;
    #1;
    en = bus.cpu_en;
    rst_lo = !bus.cpu_rst_n;
    if (bus.bp_hit) begin
      hit_cnt++;
      last_id = bus.bp_id;
    end
    if (bus.rom_we) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
      chk("rom_write", {16'h0, bus.rom_addr, bus.rom_wdata}, {16'h0, e});
    end
    @(posedge clk);
    #1;
    if (rst_lo) pc = 8'h00;
    else if (en) begin
      pc = pc + 8'h01;
      en_cnt++;
    end
    #1;
  endtask

  task automatic idle();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic cmd(input logic [2:0] op, input logic [7:0] arg, input logic [BP_IDX_W-1:0] idx, input logic exp_rdy);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op;
    bus.cmd_arg = arg;
    bus.cmd_idx = idx;
    #1;
    chk($sformatf("cmd_ready_op%0d", op), 32'(bus.cmd_ready), 32'(exp_rdy));
    if (exp_rdy)
      case (op)
        CMD_SET_ADDR: ptr = arg;
        CMD_LOAD: begin
          exp_q.push_back({ptr, arg});
          ptr = ptr + 8'h01;
        end
        CMD_SET_BP: if (int'(idx) < NUM_BP) begin
          bp_addr[idx] = arg;
          bp_en[idx] = 1'b1;
        end
        CMD_CLR_BP: if (int'(idx) < NUM_BP) bp_en[idx] = 1'b0;
        CMD_SOFT_RESET: ptr = 8'h00;
        default: ;
      endcase
    tick();
  endtask

  // Cycles of execution before RUN from p stops: the first instruction always runs.
  function automatic int run_len(input logic [7:0] p);
    int n = 0;
    int d;
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i]) begin
        d = int'(8'(bp_addr[i] - p - 8'h01)) + 1;
        if (n == 0 || d < n) n = d;
      end
    return n;
  endfunction

  function automatic int stop_id(input logic [7:0] a);
    for (int i = 0; i < NUM_BP; i++)
      if (bp_en[i] && bp_addr[i] == a) return i;
    return -1;
  endfunction

  task automatic wait_halt(input string tag);
    int c = 0;
    while (!bus.halted && c < 600) begin
      tick();
      c++;
    end
    chk({tag, "_halted"}, 32'(bus.halted), 32'd1);
  endtask

  task automatic wait_rst(input string tag);
    int c = 0;
    while (!bus.cpu_rst_n && c < 20) begin
      tick();
      c++;
    end
    chk({tag, "_rst_cycles"}, 32'(c), 32'(RST_CYC));
  endtask

  task automatic reach(input logic [7:0] a, input string tag);
    int c = 0;
    while (pc != a && c < 300) begin
      tick();
      c++;
    end
    chk({tag, "_reach_pc"}, 32'(pc), 32'(a));
  endtask

  task automatic run_to_bp(input string tag);
    logic [7:0] p;
    int n, id;
    p = pc;
    n = run_len(p);
    id = stop_id(8'(p + 8'(n)));
    en_cnt = 0;
    hit_cnt = 0;
    cmd(CMD_RUN, 8'h00, '0, 1'b1);
    idle();
    wait_halt(tag);
    tick();
    chk({tag, "_en_cycles"}, 32'(en_cnt), 32'(n));
    chk({tag, "_pc"}, 32'(pc), 32'(8'(p + 8'(n))));
    chk({tag, "_hits"}, 32'(hit_cnt), 32'd1);
    chk({tag, "_bp_id"}, 32'(last_id), 32'(id));
  endtask

  initial begin
    int n;
    for (int i = 0; i < NUM_BP; i++) begin
      bp_en[i] = 1'b0;
      bp_addr[i] = 8'h00;
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_op = CMD_SET_ADDR;
    bus.cmd_arg = 8'h00;
    bus.cmd_idx = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_cpu_rst_n", 32'(bus.cpu_rst_n), 32'd0);
    chk("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
    chk("rst_rom_we", 32'(bus.rom_we), 32'd0);
    chk("rst_bp_hit", 32'(bus.bp_hit), 32'd0);
    chk("rst_bp_id", 32'(bus.bp_id), 32'd0);
    chk("rst_halted", 32'(bus.halted), 32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    nReset = 1'b1;
    wait_rst("por");
    chk("por_halted", 32'(bus.halted), 32'd1);
    chk("por_cpu_en", 32'(bus.cpu_en), 32'd0);
    chk("por_rom_we", 32'(bus.rom_we), 32'd0);
    chk("por_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    cmd(CMD_SET_ADDR, 8'hFE, '0, 1'b1);
    cmd(CMD_LOAD, 8'hA1, '0, 1'b1);
    cmd(CMD_LOAD, 8'hB2, '0, 1'b1);
    cmd(CMD_LOAD, 8'hC3, '0, 1'b1);
    idle();
    tick();
    tick();
    chk("load_wrap_drained", 32'(exp_q.size()), 32'd0);
    for (int r = 0; r < 4; r++) begin
      cmd(CMD_SET_ADDR, 8'($urandom), '0, 1'b1);
      repeat ($urandom_range(1, 5)) cmd(CMD_LOAD, 8'($urandom), '0, 1'b1);
      idle();
      repeat ($urandom_range(1, 2)) tick();
    end
    chk("load_rand_drained", 32'(exp_q.size()), 32'd0);
    cmd(CMD_SET_BP, 8'h05, 1'b0, 1'b1);
    idle();
    pc = 8'h00;
    run_to_bp("bp05");
    cmd(CMD_SET_BP, 8'h08, 1'b1, 1'b1);
    idle();
    run_to_bp("bp08_resume");
    n = run_len(pc);
    en_cnt = 0;
    hit_cnt = 0;
    cmd(CMD_RUN, 8'h00, '0, 1'b1);
    idle();
    cmd(CMD_LOAD, 8'h77, '0, 1'b0);
    idle();
    reach(8'h05, "halt_bp");
    cmd(CMD_HALT, 8'h00, '0, 1'b1);
    idle();
    tick();
    chk("halt_bp_halted", 32'(bus.halted), 32'd1);
    chk("halt_bp_hits", 32'(hit_cnt), 32'd1);
    chk("halt_bp_id", 32'(last_id), 32'd0);
    chk("halt_bp_en_cycles", 32'(en_cnt), 32'(n));
    chk("run_load_ignored", 32'(exp_q.size()), 32'd0);
    pc = 8'h10;
    en_cnt = 0;
    hit_cnt = 0;
    cmd(CMD_STEP, 8'd3, '0, 1'b1);
    idle();
    wait_halt("step3");
    tick();
    chk("step3_en_cycles", 32'(en_cnt), 32'd3);
    chk("step3_pc", 32'(pc), 32'h13);
    en_cnt = 0;
    cmd(CMD_STEP, 8'd0, '0, 1'b1);
    idle();
    repeat (3) tick();
    chk("step0_en_cycles", 32'(en_cnt), 32'd0);
    chk("step0_halted", 32'(bus.halted), 32'd1);
    en_cnt = 0;
    cmd(CMD_STEP, 8'd2, '0, 1'b1);
    idle();
    tick();
    cmd(CMD_HALT, 8'h00, '0, 1'b1);
    idle();
    tick();
    chk("step_last_halt_en", 32'(en_cnt), 32'd2);
    chk("step_last_halt_halted", 32'(bus.halted), 32'd1);
    for (int r = 0; r < 6; r++) begin
      logic [7:0] p;
      int k;
      p = 8'($urandom);
      k = $urandom_range(1, 40);
      pc = p;
      en_cnt = 0;
      hit_cnt = 0;
      cmd(CMD_STEP, 8'(k), '0, 1'b1);
      idle();
      wait_halt("rstep");
      tick();
      chk("rstep_en_cycles", 32'(en_cnt), 32'(k));
      chk("rstep_pc", 32'(pc), 32'(8'(p + 8'(k))));
      chk("rstep_no_hit", 32'(hit_cnt), 32'd0);
    end
    for (int r = 0; r < 6; r++) begin
      cmd(CMD_SET_BP, 8'($urandom), 1'b0, 1'b1);
      cmd(CMD_SET_BP, 8'($urandom), 1'b1, 1'b1);
      idle();
      pc = 8'($urandom);
      run_to_bp("rrun");
    end
    cmd(CMD_SET_BP, 8'h05, 1'b0, 1'b1);
    cmd(CMD_CLR_BP, 8'h00, 1'b1, 1'b1);
    idle();
    pc = 8'h00;
    cmd(CMD_RUN, 8'h00, '0, 1'b1);
    idle();
    reach(8'h05, "srst");
    hit_cnt = 0;
    cmd(CMD_SOFT_RESET, 8'h00, '0, 1'b1);
    idle();
    wait_rst("srst");
    tick();
    chk("srst_hits", 32'(hit_cnt), 32'd0);
    chk("srst_halted", 32'(bus.halted), 32'd1);
    chk("srst_pc", 32'(pc), 32'h00);
    cmd(CMD_LOAD, 8'h5A, '0, 1'b1);
    idle();
    tick();
    chk("srst_load_drained", 32'(exp_q.size()), 32'd0);
    run_to_bp("srst_bp_kept");
    cmd(CMD_LOAD, 8'h66, '0, 1'b1);
    nReset = 1'b0;
    #1;
    chk("reset_mid_load_rom_we", 32'(bus.rom_we), 32'd0);
    void'(exp_q.pop_back());
    ptr = 8'h00;
    for (int i = 0; i < NUM_BP; i++) bp_en[i] = 1'b0;
    idle();
    @(posedge clk);
    #2;
    nReset = 1'b1;
    wait_rst("areset");
    pc = 8'h05;
    en_cnt = 0;
    hit_cnt = 0;
    cmd(CMD_RUN, 8'h00, '0, 1'b1);
    idle();
    repeat (10) tick();
    chk("areset_bp_cleared_en", 32'(en_cnt), 32'd10);
    chk("areset_bp_cleared_hits", 32'(hit_cnt), 32'd0);
    cmd(CMD_HALT, 8'h00, '0, 1'b1);
    idle();
    tick();
    chk("areset_halted", 32'(bus.halted), 32'd1);
    chk("final_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
